// File: rtl/dsram_like_resp_pkg.sv
// dsram_like_resp_pkg: shared types and constants for the data_sram responder.
// Pending-queue entry layout, size codes, latency bound and LFSR step.
package dsram_like_resp_pkg;

  localparam logic [1:0] DSRAM_SIZE_B = 2'd0;
  localparam logic [1:0] DSRAM_SIZE_H = 2'd1;
  localparam logic [1:0] DSRAM_SIZE_W = 2'd2;
  localparam int         DSRAM_LAT_MAX = 15;

  typedef struct packed {
    logic        wr;
    logic [3:0]  cnt;
    logic [31:0] rdata;
  } pend_ent_t;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/dsram_pend_q.sv
// dsram_pend_q: circular queue of accepted-but-unanswered requests.
// Each entry counts down to maturity; the head pops when it matures.
module dsram_pend_q
  import dsram_like_resp_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int LAT    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic        push_wr,
  input  logic [31:0] ld_word,
  output logic        head_mature,
  output logic        head_wr,
  output logic [31:0] head_data,
  output logic [3:0]  count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [3:0] LAT_CNT = 4'(LAT);

  pend_ent_t         ent_q [QDEPTH];
  pend_ent_t         ent_d [QDEPTH];
  logic [QDEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     cap_ptr_q, cap_ptr_d;
  logic              cap_q, cap_d;
  logic [3:0]        count_q, count_d;
  logic              pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The load word read at the accept edge lands in its entry one edge later;
  // until then the head forwards it straight from the memory read register.
  assign head_mature = vld_q[rd_ptr_q] && (ent_q[rd_ptr_q].cnt == 4'd1);
  assign pop         = head_mature;
  assign head_wr     = ent_q[rd_ptr_q].wr;
  assign head_data   = (cap_q && (cap_ptr_q == rd_ptr_q)) ?
                       ld_word : ent_q[rd_ptr_q].rdata;
  assign count       = count_q;

  // next state: countdown, load capture, pop, push
  always_comb begin
    ent_d     = ent_q;
    vld_d     = vld_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cap_d     = push && !push_wr;
    cap_ptr_d = wr_ptr_q;
    for (int i = 0; i < QDEPTH; i++) begin
      if (vld_q[i] && (ent_q[i].cnt > 4'd1))
        ent_d[i].cnt = ent_q[i].cnt - 4'd1;
    end
    if (cap_q)
      ent_d[cap_ptr_q].rdata = ld_word;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = inc(rd_ptr_q);
    end
    if (push) begin
      vld_d[wr_ptr_q]       = 1'b1;
      ent_d[wr_ptr_q].wr    = push_wr;
      ent_d[wr_ptr_q].cnt   = LAT_CNT;
      ent_d[wr_ptr_q].rdata = '0;
      wr_ptr_d              = inc(wr_ptr_q);
    end
    count_d = count_q + {3'b0, push} - {3'b0, pop};
  end

  // control state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cap_ptr_q <= '0;
      cap_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      vld_q     <= vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cap_ptr_q <= cap_ptr_d;
      cap_q     <= cap_d;
      count_q   <= count_d;
    end
  end

  // entry payload register, qualified by vld_q
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: rtl/dsram_like_resp.sv
// dsram_like_resp: data_sram req/addr_ok/data_ok responder with word memory.
// Define DSRAM_STALL_INJECT_EN for LFSR-driven addr_ok backpressure.
module dsram_like_resp
  import dsram_like_resp_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter int          LAT       = 1,
  parameter int          QDEPTH    = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              accept, st_acc, ld_acc, stall;
  logic              head_mature, head_wr;
  logic [31:0]       head_data, resp_word, rd_word_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        count;
  logic              unused_ok;

  // size only matters to the master's lane extraction
  assign unused_ok = ^{data_sram_size, data_sram_addr[31:ADDR_W+2],
                       data_sram_addr[1:0]};

  assign idx               = data_sram_addr[ADDR_W+1:2];
  assign data_sram_addr_ok = (count < 4'(QDEPTH)) && !stall;
  assign accept            = rstn && data_sram_req && data_sram_addr_ok;
  assign st_acc            = accept && data_sram_wr;
  assign ld_acc            = accept && !data_sram_wr;

`ifdef DSRAM_STALL_INJECT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // free-running stall generator
  always_comb lfsr_d = lfsr_next(lfsr_q);

  // LFSR register, reseeded on reset
  always_ff @(posedge clk) begin
    if (!rstn) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic [15:0] unused_seed;
  assign unused_seed = LFSR_SEED;
  assign stall       = 1'b0;
`endif

  // stores commit at accept; loads read synchronously at accept
  always_ff @(posedge clk) begin
    if (st_acc) begin
      for (int b = 0; b < 4; b++)
        if (data_sram_wstrb[b])
          mem[idx][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
    end
    if (ld_acc) rd_word_q <= mem[idx];
  end

  dsram_pend_q #(
    .QDEPTH (QDEPTH),
    .LAT    (LAT)
  ) u_pend_q (
    .clk         (clk),
    .rstn        (rstn),
    .push        (accept),
    .push_wr     (data_sram_wr),
    .ld_word     (rd_word_q),
    .head_mature (head_mature),
    .head_wr     (head_wr),
    .head_data   (head_data),
    .count       (count)
  );

  // response word: zero on stores, held between responses
  always_comb begin
    resp_word = head_wr ? '0 : head_data;
    rdata_d   = rdata_q;
    if (head_mature) rdata_d = resp_word;
  end

  // last response word
  always_ff @(posedge clk) begin
    if (!rstn) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign data_sram_data_ok = head_mature;
  assign data_sram_rdata   = rdata_d;

endmodule

// File: tb/tb_dsram_like_resp.sv
// tb_dsram_like_resp: directed vectors on a LAT=1 responder,
// scoreboard-checked sequences on a LAT=3 responder.
module tb_dsram_like_resp;
  import dsram_like_resp_pkg::*;

  localparam int LAT3 = 3;
  localparam int QD3  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, req, wr, addr_ok, data_ok;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, rdata;

  logic        rstn3, req3, wr3, addr_ok3, data_ok3;
  logic [1:0]  size3;
  logic [3:0]  wstrb3;
  logic [31:0] addr3, wdata3, rdata3;

  dsram_like_resp u_dut (
    .clk               (clk),
    .rstn              (rstn),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_wstrb   (wstrb),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  dsram_like_resp #(
    .ADDR_W (8),
    .LAT    (LAT3),
    .QDEPTH (QD3)
  ) u_dut3 (
    .clk               (clk),
    .rstn              (rstn3),
    .data_sram_req     (req3),
    .data_sram_wr      (wr3),
    .data_sram_size    (size3),
    .data_sram_wstrb   (wstrb3),
    .data_sram_addr    (addr3),
    .data_sram_wdata   (wdata3),
    .data_sram_addr_ok (addr_ok3),
    .data_sram_data_ok (data_ok3),
    .data_sram_rdata   (rdata3)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ok;
    logic        dok;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [15];

  typedef struct {
    int          cyc;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq [$];
  exp_t        e;
  logic [31:0] refm [256];
  logic [7:0]  ix;
  logic        mon_en = 1'b0;
  int          acc3 = 0;
  int          dok3 = 0;

  // scoreboard for the LAT=3 instance
  always @(negedge clk) begin
    if (!rstn3) begin
      sbq.delete();
    end else if (mon_en) begin
      vecs++;
      if (addr_ok3 && (sbq.size() >= QD3)) begin
        errs++;
        $display("FAIL full_addr_ok: got addr_ok=1 want 0 with %0d pending",
                 sbq.size());
      end
      if (data_ok3) begin
        dok3++;
        if (sbq.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL spurious_data_ok: got data_ok=1 want 0 at cyc %0d",
                   cyc);
        end else begin
          e = sbq.pop_front();
          chk("dok_cycle", cyc, e.cyc);
          chk("dok_rdata", rdata3, e.rd);
        end
      end
      if (req3 && addr_ok3) begin
        acc3++;
        ix = addr3[9:2];
        if (wr3) begin
          for (int b = 0; b < 4; b++)
            if (wstrb3[b]) refm[ix][b*8 +: 8] = wdata3[b*8 +: 8];
          sbq.push_back('{cyc + LAT3, 32'h0});
        end else begin
          sbq.push_back('{cyc + LAT3, refm[ix]});
        end
      end
    end
  end

  task automatic idle3();
    req3 = 1'b0; wr3 = 1'b0; size3 = 2'd2;
    wstrb3 = 4'h0; addr3 = '0; wdata3 = '0;
  endtask

  // call at #1 after a posedge; returns at #1 after the accept edge
  task automatic issue3(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    req3 = 1'b1; wr3 = w; size3 = 2'd2;
    addr3 = a; wdata3 = d; wstrb3 = s;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (addr_ok3) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    vecs++;
    errs++;
    $display("FAIL accept_timeout: got no addr_ok want accept at %h", a);
    idle3();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1, 1, 2'd2, 4'hF, 32'h1000,  32'h12345678, 1, 0, 32'h0};
    tv[1]  = '{1, 0, 2'd2, 4'h0, 32'h1000,  32'h0,        1, 1, 32'h0};
    tv[2]  = '{0, 0, 2'd2, 4'h0, 32'h0,     32'h0,        1, 1, 32'h12345678};
    tv[3]  = '{1, 1, 2'd0, 4'h8, 32'h1003,  32'hAAAAAAAA, 1, 0, 32'h12345678};
    tv[4]  = '{1, 1, 2'd1, 4'h3, 32'h1000,  32'hBEEFBEEF, 1, 1, 32'h0};
    tv[5]  = '{1, 0, 2'd2, 4'h0, 32'h1000,  32'h0,        1, 1, 32'h0};
    tv[6]  = '{0, 0, 2'd2, 4'h0, 32'h0,     32'h0,        1, 1, 32'hAA34BEEF};
    tv[7]  = '{0, 0, 2'd2, 4'h0, 32'h0,     32'h0,        1, 0, 32'hAA34BEEF};
    tv[8]  = '{1, 1, 2'd2, 4'hF, 32'h4,     32'hCAFEF00D, 1, 0, 32'hAA34BEEF};
    tv[9]  = '{1, 0, 2'd2, 4'h0, 32'h10004, 32'h0,        1, 1, 32'h0};
    tv[10] = '{0, 0, 2'd2, 4'h0, 32'h0,     32'h0,        1, 1, 32'hCAFEF00D};
    tv[11] = '{1, 0, 2'd2, 4'h0, 32'h1000,  32'h0,        1, 0, 32'hCAFEF00D};
    tv[12] = '{1, 0, 2'd2, 4'h0, 32'h4,     32'h0,        1, 1, 32'hAA34BEEF};
    tv[13] = '{0, 0, 2'd2, 4'h0, 32'h0,     32'h0,        1, 1, 32'hCAFEF00D};
    tv[14] = '{0, 0, 2'd2, 4'h0, 32'h0,     32'h0,        1, 0, 32'hCAFEF00D};

    rstn = 1'b0; rstn3 = 1'b0;
    req = 1'b0; wr = 1'b0; size = 2'd2;
    wstrb = 4'h0; addr = '0; wdata = '0;
    idle3();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_data_ok", data_ok, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_data_ok3", data_ok3, 1'b0);
    chk("rst_rdata3", rdata3, 32'h0);
    rstn = 1'b1; rstn3 = 1'b1;
    @(negedge clk);
    chk("post_rst_addr_ok", addr_ok, 1'b1);
    chk("post_rst_addr_ok3", addr_ok3, 1'b1);
    mon_en = 1'b1;

`ifndef DSRAM_STALL_INJECT_EN
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      req = tv[i].req; wr = tv[i].wr; size = tv[i].size;
      wstrb = tv[i].wstrb; addr = tv[i].addr; wdata = tv[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_addr_ok", i), addr_ok, tv[i].ok);
      chk($sformatf("v%0d_data_ok", i), data_ok, tv[i].dok);
      chk($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
    end
    req = 1'b0;
`endif

    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++)
      issue3(1'b1, 32'h40 + 32'(i * 4), 32'hA5000000 | 32'(i * 32'h10101),
             4'hF);
    idle3();
    repeat (6) @(posedge clk);
    #1;

    issue3(1'b0, 32'h40, 32'h0, 4'h0);
    issue3(1'b0, 32'h44, 32'h0, 4'h0);
`ifndef DSRAM_STALL_INJECT_EN
    @(negedge clk);
    chk("q_full_addr_ok", addr_ok3, 1'b0);
    @(posedge clk);
    #1;
`endif
    issue3(1'b0, 32'h48, 32'h0, 4'h0);
    issue3(1'b0, 32'h4C, 32'h0, 4'h0);
    idle3();
    repeat (6) @(posedge clk);
    #1;

    issue3(1'b1, 32'h50, 32'h0BADC0DE, 4'hF);
    idle3();
    repeat (4) @(posedge clk);
    #1;
    begin
      int d0;
      issue3(1'b0, 32'h54, 32'h0, 4'h0);
      issue3(1'b0, 32'h58, 32'h0, 4'h0);
      idle3();
      rstn3 = 1'b0;
      @(posedge clk);
      #1;
      rstn3 = 1'b1;
      d0 = dok3;
      @(negedge clk);
      chk("rst_mid_addr_ok", addr_ok3, 1'b1);
      repeat (8) @(negedge clk);
      chk("rst_mid_no_dok", dok3, d0);
      @(posedge clk);
      #1;
      issue3(1'b0, 32'h50, 32'h0, 4'h0);
      idle3();
      repeat (5) @(posedge clk);
      chk("rst_mem_kept", rdata3, 32'h0BADC0DE);
      #1;
    end

    acc3 = 0;
    dok3 = 0;
    for (int n = 0; n < 300; n++) begin
      logic        w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = 32'h40 + 32'($urandom_range(0, 15) * 4);
      issue3(w, a, $urandom, 4'($urandom_range(1, 15)));
      if ($urandom_range(0, 2) == 0) begin
        idle3();
        @(posedge clk);
        #1;
      end
    end
    idle3();
    for (int n = 0; n < 40 && sbq.size() != 0; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(sbq.size()), 32'h0);
    chk("one_dok_per_accept", dok3, acc3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
